fpu_result_collector: RTL and testbench

//  Downstream stage of the single-precision FPU. Tracks each op issued to the FPU through its fixed

---
 rtl/fpu_pkg.sv | 33 +++
 rtl/fpu_result_fifo.sv | 57 +++++
 rtl/fpu_result_collector.sv | 106 ++++++++++
 tb/tb_fpu_result_collector.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared opcodes, flag indices, reference FP constants and the result entry layout
// for the FPU result collector.
package fpu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  localparam int FLG_INF  = 7;
  localparam int FLG_SNAN = 6;
  localparam int FLG_QNAN = 5;
  localparam int FLG_INE  = 4;
  localparam int FLG_OVF  = 3;
  localparam int FLG_UNF  = 2;
  localparam int FLG_ZERO = 1;
  localparam int FLG_DBZ  = 0;

  localparam logic [31:0] FP_INF  = 32'h7F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_MAX  = 32'h7F7F_FFFF;

  localparam int RES_TAG_W = 4;

  typedef struct packed {
    logic [31:0]          result;
    logic [7:0]           flags;
    logic [2:0]           op;
    logic [RES_TAG_W-1:0] tag;
  } res_entry_t;

endpackage

// File: rtl/fpu_result_fifo.sv
// First-word fall-through sync FIFO holding packed result entries.
// Pop is ignored when empty; push while full is accepted only alongside a pop.
module fpu_result_fifo
  import fpu_pkg::*;
#(
  parameter int W     = $bits(res_entry_t),
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
    if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fpu_result_collector.sv
// Tracks ops through the fixed FPU latency, captures result+flags on arrival and
// offers them in order on a valid/ready port with sticky flag/error status.
module fpu_result_collector
  import fpu_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [2:0]       issue_op_i,
  input  logic [TAG_W-1:0] issue_tag_i,
  input  logic [31:0]      fpu_out_i,
  input  logic [7:0]       fpu_flags_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_result_o,
  output logic [7:0]       out_flags_o,
  output logic [2:0]       out_op_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic [7:0]       sticky_flags_o,
  input  logic             sticky_clr_i,
  output logic             proto_err_o,
  output logic             flag_err_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int INF_W = $clog2(LATENCY + 1);
  localparam int PD_W  = 3 + TAG_W;
  localparam int ENT_W = 32 + 8 + PD_W;

  logic [LATENCY-1:0]           pv_q, pv_d;
  logic [LATENCY-1:0][PD_W-1:0] pd_q, pd_d;
  logic [7:0]                   sticky_q, sticky_d;
  logic                         perr_q, perr_d;
  logic                         ferr_q, ferr_d;
  logic [INF_W-1:0]             inflight;
  logic [CNT_W-1:0]             buf_cnt;
  logic                         accept, push, pop;
  logic [ENT_W-1:0]             wdata, rdata;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + INF_W'(pv_q[i]);
  end

  // Credit counts both buffered entries and ops still inside the FPU.
  assign issue_ready_o = (int'(buf_cnt) + int'(inflight)) < DEPTH;
  assign accept        = issue_valid_i & issue_ready_o;
  assign push          = pv_q[LATENCY-1];
  assign out_valid_o   = (buf_cnt != '0);
  assign pop           = out_valid_o & out_ready_i;
  assign wdata         = {fpu_out_i, fpu_flags_i, pd_q[LATENCY-1]};

  always_comb begin
    pv_d[0] = accept;
    pd_d[0] = {issue_op_i, issue_tag_i};
    for (int i = 1; i < LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
    // A flag captured in the clear cycle survives the clear.
    sticky_d = (sticky_clr_i ? 8'h00 : sticky_q) | (push ? fpu_flags_i : 8'h00);
    perr_d   = (sticky_clr_i ? 1'b0 : perr_q) | (issue_valid_i & ~issue_ready_o);
    ferr_d   = (sticky_clr_i ? 1'b0 : ferr_q)
             | (push & fpu_flags_i[FLG_OVF] & fpu_flags_i[FLG_UNF]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pv_q     <= '0;
      pd_q     <= '0;
      sticky_q <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      pv_q     <= pv_d;
      pd_q     <= pd_d;
      sticky_q <= sticky_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  fpu_result_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .count_o (buf_cnt)
  );

  assign {out_result_o, out_flags_o, out_op_o, out_tag_o} = rdata;
  assign sticky_flags_o = sticky_q;
  assign proto_err_o    = perr_q;
  assign flag_err_o     = ferr_q;

endmodule

// File: tb/tb_fpu_result_collector.sv
// Randomized plus directed bench for fpu_result_collector, checked every cycle
// against a queue-based model of the collector's externally visible behaviour.
module tb_fpu_result_collector;
  import fpu_pkg::*;

  localparam int LATENCY = 4;
  localparam int DEPTH   = 8;
  localparam int TAG_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             issue_valid;
  logic             issue_ready;
  logic [2:0]       issue_op;
  logic [TAG_W-1:0] issue_tag;
  logic [31:0]      fpu_out;
  logic [7:0]       fpu_flags;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [7:0]       out_flags;
  logic [2:0]       out_op;
  logic [TAG_W-1:0] out_tag;
  logic [7:0]       sticky_flags;
  logic             sticky_clr;
  logic             proto_err;
  logic             flag_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_result_collector #(.LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .issue_valid_i  (issue_valid),
    .issue_ready_o  (issue_ready),
    .issue_op_i     (issue_op),
    .issue_tag_i    (issue_tag),
    .fpu_out_i      (fpu_out),
    .fpu_flags_i    (fpu_flags),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_result_o   (out_result),
    .out_flags_o    (out_flags),
    .out_op_o       (out_op),
    .out_tag_o      (out_tag),
    .sticky_flags_o (sticky_flags),
    .sticky_clr_i   (sticky_clr),
    .proto_err_o    (proto_err),
    .flag_err_o     (flag_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ops waiting in the FPU with their arrival edge, and the ordered result buffer.
  typedef struct {
    int         due;
    logic [2:0] op;
    logic [3:0] tag;
  } pend_t;

  pend_t      pend_q[$];
  res_entry_t fifo_m[$];
  logic [7:0] m_sticky;
  logic       m_perr, m_ferr;
  bit         live = 0;
  int         edge_n = 0;

  always @(posedge clk) begin
    bit         ready, pop, push;
    res_entry_t e;
    pend_t      p;
    if (!rst_n) begin
      pend_q.delete();
      fifo_m.delete();
      m_sticky = 8'h00;
      m_perr   = 1'b0;
      m_ferr   = 1'b0;
      live     = 1;
    end else begin
      ready = (fifo_m.size() + pend_q.size()) < DEPTH;
      pop   = (fifo_m.size() > 0) && out_ready;
      push  = (pend_q.size() > 0) && (pend_q[0].due == edge_n);
      if (push) begin
        p        = pend_q.pop_front();
        e.result = fpu_out;
        e.flags  = fpu_flags;
        e.op     = p.op;
        e.tag    = p.tag;
      end
      m_sticky = (sticky_clr ? 8'h00 : m_sticky) | (push ? fpu_flags : 8'h00);
      m_perr   = (sticky_clr ? 1'b0 : m_perr) | (issue_valid && !ready);
      m_ferr   = (sticky_clr ? 1'b0 : m_ferr) | (push && fpu_flags[3] && fpu_flags[2]);
      if (pop) void'(fifo_m.pop_front());
      if (push) fifo_m.push_back(e);
      if (issue_valid && ready) begin
        p.due = edge_n + LATENCY;
        p.op  = issue_op;
        p.tag = issue_tag;
        pend_q.push_back(p);
      end
    end
    edge_n++;
  end

  always @(negedge clk) begin
    if (live) begin
      chk("issue_ready", 32'(issue_ready), 32'((fifo_m.size() + pend_q.size()) < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(fifo_m.size() > 0));
      if (fifo_m.size() > 0) begin
        chk("out_result", out_result, fifo_m[0].result);
        chk("out_flags", 32'(out_flags), 32'(fifo_m[0].flags));
        chk("out_op", 32'(out_op), 32'(fifo_m[0].op));
        chk("out_tag", 32'(out_tag), 32'(fifo_m[0].tag));
      end
      chk("sticky_flags", 32'(sticky_flags), 32'(m_sticky));
      chk("proto_err", 32'(proto_err), 32'(m_perr));
      chk("flag_err", 32'(flag_err), 32'(m_ferr));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] tag);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_tag   = tag;
    tick();
    issue_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_op = '0; issue_tag = '0;
    fpu_out = '0; fpu_flags = '0; out_ready = 1'b0; sticky_clr = 1'b0;
    tick(2);
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_sticky", 32'(sticky_flags), 32'h00);
    chk("rst_proto_err", 32'(proto_err), 32'd0);

    // 1: 1.0 + 1.0 arrives exactly LATENCY edges after accept
    fpu_out = 32'h4000_0000; fpu_flags = 8'h00; out_ready = 1'b1;
    issue(OP_ADD, 4'd3);
    tick(LATENCY - 1);
    chk("t1_not_early", 32'(out_valid), 32'd0);
    tick();
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_result", out_result, 32'h4000_0000);
    chk("t1_op", 32'(out_op), 32'(OP_ADD));
    chk("t1_tag", 32'(out_tag), 32'd3);
    tick(2);

    // 2: fill with consumer stalled, ninth op violates credit
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      fpu_out = $urandom();
      if (i == 7) chk("t2_ready_before_8th", 32'(issue_ready), 32'd1);
      if (i == 8) chk("t2_ready_after_8th", 32'(issue_ready), 32'd0);
      issue_valid = 1'b1; issue_op = OP_MUL; issue_tag = 4'(i);
      tick();
    end
    issue_valid = 1'b0;
    chk("t2_proto_err", 32'(proto_err), 32'd1);
    tick(LATENCY + 2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain_valid", 32'(out_valid), 32'd1);
      chk("t2_drain_tag", 32'(out_tag), 32'(i));
      tick();
    end
    chk("t2_empty_after", 32'(out_valid), 32'd0);
    sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    chk("t2_perr_cleared", 32'(proto_err), 32'd0);

    // 3: divide by zero flag, then clear
    fpu_out = FP_INF; fpu_flags = 8'h01;
    issue(OP_DIV, 4'd5);
    tick(LATENCY);
    chk("t3_out_flags", 32'(out_flags), 32'h01);
    chk("t3_sticky", 32'(sticky_flags), 32'h01);
    tick();
    sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    chk("t3_sticky_cleared", 32'(sticky_flags), 32'h00);

    // 4: push in the clear cycle survives the clear
    fpu_flags = 8'h81;
    issue(OP_SUB, 4'd1);
    tick(LATENCY);
    chk("t4_prior_sticky", 32'(sticky_flags), 32'h81);
    fpu_flags = 8'h00;
    issue(OP_ADD, 4'd2);
    tick(LATENCY - 1);
    fpu_flags = 8'h20; sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0; fpu_flags = 8'h00;
    chk("t4_sticky_after_clr", 32'(sticky_flags), 32'h20);
    tick(2);

    // 5: overflow+underflow together raises flag_err, entry still delivered
    fpu_out = FP_MAX; fpu_flags = 8'h0C;
    issue(3'b110, 4'd9);
    tick(LATENCY);
    chk("t5_flag_err", 32'(flag_err), 32'd1);
    chk("t5_out_flags", 32'(out_flags), 32'h0C);
    chk("t5_out_op", 32'(out_op), 32'h6);
    fpu_flags = 8'h00;
    tick(2);

    // 6: reset with three ops in flight discards them
    for (int i = 0; i < 3; i++) issue(OP_MUL, 4'(10 + i));
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_issue_ready", 32'(issue_ready), 32'd1);
    chk("t6_sticky", 32'(sticky_flags), 32'h00);
    chk("t6_flag_err", 32'(flag_err), 32'd0);
    for (int i = 0; i < LATENCY + 2; i++) begin
      fpu_out = $urandom(); fpu_flags = 8'hFF;
      tick();
      chk("t6_no_ghost", 32'(out_valid), 32'd0);
    end
    fpu_flags = 8'h00;

    // Random traffic with bursty consumer, rare clears and resets
    for (int c = 0; c < 3000; c++) begin
      issue_valid = issue_ready ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 4);
      issue_op    = 3'($urandom());
      issue_tag   = 4'($urandom());
      fpu_out     = $urandom();
      fpu_flags   = 8'($urandom() & $urandom() & $urandom());
      out_ready   = ((c / 64) % 3 == 1) ? ($urandom_range(0, 99) < 15) : ($urandom_range(0, 99) < 70);
      sticky_clr  = ($urandom_range(0, 99) < 3);
      rst_n       = ($urandom_range(0, 999) >= 2);
      tick();
    end
    issue_valid = 1'b0; sticky_clr = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
    tick(LATENCY + DEPTH + 2);
    chk("final_drained", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
